// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_sequencer                                                  |
// | Purpose  : Fetch/control sequencer for a 16-bit program counter. Each    |
// |            instruction cycle fetches the word at the current PC over a   |
// |            req/ack memory port, decodes its 2-bit class and issues one   |
// |            PC command (RESET/PRESET/INCR/HALT).                          |
// | Ports    : clock, reset (sync, active-low), start                        |
// |            pc_out_i  <- current PC      opcode/pc_in -> PC command       |
// |            mem_req/mem_addr -> memory   mem_ack/mem_rdata <- memory      |
// |            zero_flag <- branch condition                                 |
// |            instr/instr_valid -> fetched instruction, busy/halted status  |
// | Options  : PC_SEQ_BRANCH_EN - class 10 becomes BRZ (PC-relative branch   |
// |            taken when zero_flag is set); otherwise class 10 is a NOP.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pc_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_out_i,
  output logic [1:0]  opcode,
  output logic [15:0] pc_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        zero_flag,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_RST_PC = 3'd1;
  localparam logic [2:0] c_ST_FETCH  = 3'd2;
  localparam logic [2:0] c_ST_UPDATE = 3'd3;
  localparam logic [2:0] c_ST_HALTED = 3'd4;

  localparam logic [1:0] c_OP_RESET  = 2'd0;
  localparam logic [1:0] c_OP_PRESET = 2'd1;
  localparam logic [1:0] c_OP_INCR   = 2'd2;
  localparam logic [1:0] c_OP_HALT   = 2'd3;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;

  logic [1:0]  r_opcode;
  logic [15:0] r_pc_in;
  logic        r_mem_req;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic        r_busy;
  logic        r_halted;

  logic [1:0]  w_opcode_nxt;
  logic [15:0] w_pc_in_nxt;
  logic        w_mem_req_nxt;
  logic [15:0] w_instr_nxt;
  logic        w_instr_valid_nxt;

  logic [1:0]  w_dec_cmd;
  logic [15:0] w_dec_target;
  logic        w_dec_halt;

  // Decode works straight off mem_rdata so the command can be registered on
  // the same edge the instruction is captured.
`ifdef PC_SEQ_BRANCH_EN
  logic [15:0] w_branch_off;
  assign w_branch_off = {{2{mem_rdata[13]}}, mem_rdata[13:0]};
`else
  logic w_unused_zero_flag;
  assign w_unused_zero_flag = zero_flag;
`endif

  always_comb begin
    w_dec_cmd    = c_OP_INCR;
    w_dec_target = r_pc_in;   // pc_in only moves when a PRESET is issued
    w_dec_halt   = 1'b0;
    case (mem_rdata[15:14])
      2'b01: begin
        w_dec_cmd    = c_OP_PRESET;
        w_dec_target = {2'b00, mem_rdata[13:0]};
      end
`ifdef PC_SEQ_BRANCH_EN
      2'b10: begin
        if (zero_flag) begin
          w_dec_cmd    = c_OP_PRESET;
          w_dec_target = pc_out_i + w_branch_off;
        end
      end
`endif
      2'b11: begin
        w_dec_cmd  = c_OP_HALT;
        w_dec_halt = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= c_ST_IDLE;
      r_opcode      <= c_OP_HALT;
      r_pc_in       <= 16'h0000;
      r_mem_req     <= 1'b0;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_opcode      <= w_opcode_nxt;
      r_pc_in       <= w_pc_in_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_busy        <= (w_next_state == c_ST_RST_PC) ||
                       (w_next_state == c_ST_FETCH)  ||
                       (w_next_state == c_ST_UPDATE);
      r_halted      <= (w_next_state == c_ST_HALTED);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (start) w_next_state = c_ST_RST_PC;
      c_ST_RST_PC: w_next_state = c_ST_FETCH;
      c_ST_FETCH: begin
        if (mem_ack) w_next_state = w_dec_halt ? c_ST_HALTED : c_ST_UPDATE;
      end
      c_ST_UPDATE: w_next_state = c_ST_FETCH;
      c_ST_HALTED: if (start) w_next_state = c_ST_UPDATE;
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  // Output logic: values the output registers take at the coming edge.
  // The PC holds (HALT) unless the next cycle is RST_PC or UPDATE.
  always_comb begin
    w_opcode_nxt      = c_OP_HALT;
    w_pc_in_nxt       = r_pc_in;
    w_mem_req_nxt     = 1'b0;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (start) w_opcode_nxt = c_OP_RESET;
      end
      c_ST_RST_PC: w_mem_req_nxt = 1'b1;
      c_ST_FETCH: begin
        if (mem_ack) begin
          w_instr_nxt       = mem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_opcode_nxt      = w_dec_cmd;
          w_pc_in_nxt       = w_dec_target;
        end else begin
          w_mem_req_nxt = 1'b1;   // hold the request through wait states
        end
      end
      c_ST_UPDATE: w_mem_req_nxt = 1'b1;
      c_ST_HALTED: begin
        if (start) w_opcode_nxt = c_OP_INCR;  // step past the HALT word
      end
      default: ;
    endcase
  end

  assign opcode      = r_opcode;
  assign pc_in       = r_pc_in;
  assign mem_req     = r_mem_req;
  assign mem_addr    = pc_out_i;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign busy        = r_busy;
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pc_sequencer                                               |
// | Purpose  : Self-checking bench for pc_sequencer. Hosts a program counter |
// |            and a memory with random wait states, and predicts every      |
// |            fetch address and issued command from the instruction rules.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] pc_out_i;
  logic [1:0]  opcode;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        zero_flag;
  logic [15:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        halted;

  int total = 0;
  int bad   = 0;
  int exp_pc = 0;            // architectural PC expected at the next fetch
  logic [15:0] last_instr = 16'h0000;

  pc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pc_out_i    (pc_out_i),
    .opcode      (opcode),
    .pc_in       (pc_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .zero_flag   (zero_flag),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program counter being sequenced; pc_load lets the bench preload it while halted.
  logic [15:0] pc_reg = 16'h1234;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  always @(posedge clock) begin
    if (pc_load) pc_reg <= pc_load_val;
    else begin
      case (opcode)
        2'd0: pc_reg <= 16'h0000;
        2'd1: pc_reg <= pc_in;
        2'd2: pc_reg <= pc_reg + 16'd1;
        default: pc_reg <= pc_reg;
      endcase
    end
  end
  assign pc_out_i = pc_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge in the first FETCH cycle. Serves 'word' after 'waits'
  // wait states, then checks the issued command. Returns at the next FETCH
  // negedge, or at the first HALTED negedge for a HALT word.
  task automatic do_fetch(input logic [15:0] word, input int waits, input logic zf);
    int exp_cmd;
    int target;
    int off;
    bit is_halt;
    for (int i = 0; i <= waits; i++) begin
      check("mem_req_held", 32'(mem_req), 32'd1);
      check("mem_addr", 32'(mem_addr), 32'(exp_pc));
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? word : 16'($urandom);
      zero_flag = (i == waits) ? zf : 1'($urandom);
      start     = 1'($urandom);
      @(negedge clock);
    end
    mem_ack   = 1'b0;
    start     = 1'b0;
    mem_rdata = 16'($urandom);

    // Reference model of the instruction set
    is_halt = 1'b0;
    exp_cmd = 2;
    target  = (exp_pc + 1) % 65536;
    case (word[15:14])
      2'b01: begin
        exp_cmd = 1;
        target  = int'(word) % 16384;
      end
      2'b10: begin
`ifdef PC_SEQ_BRANCH_EN
        if (zf) begin
          off = int'(word) % 16384;
          if (off >= 8192) off = off - 16384;
          exp_cmd = 1;
          target  = (exp_pc + off + 65536) % 65536;
        end
`endif
      end
      2'b11: begin
        exp_cmd = 3;
        is_halt = 1'b1;
      end
      default: ;
    endcase

    check("instr", 32'(instr), 32'(word));
    check("instr_valid_pulse", 32'(instr_valid), 32'd1);
    check("mem_req_dropped", 32'(mem_req), 32'd0);
    check("opcode_cmd", 32'(opcode), 32'(exp_cmd));
    if (exp_cmd == 1) check("pc_in", 32'(pc_in), 32'(target));
    last_instr = word;
    if (is_halt) begin
      check("halted_set", 32'(halted), 32'd1);
      check("busy_halt", 32'(busy), 32'd0);
    end else begin
      check("busy_update", 32'(busy), 32'd1);
      check("halted_clr", 32'(halted), 32'd0);
      exp_pc = target;
      @(negedge clock);
      check("instr_valid_end", 32'(instr_valid), 32'd0);
    end
  endtask

  // Called at the first HALTED negedge: idle n more cycles (with stray acks
  // that must be ignored), then start and expect one INCR cycle.
  task automatic resume(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack   = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clock);
      check("halt_opcode", 32'(opcode), 32'd3);
      check("halt_req", 32'(mem_req), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_instr", 32'(instr), 32'(last_instr));
      check("halt_valid", 32'(instr_valid), 32'd0);
    end
    mem_ack = 1'b0;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("resume_opcode", 32'(opcode), 32'd2);
    check("resume_busy", 32'(busy), 32'd1);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_valid", 32'(instr_valid), 32'd0);
    exp_pc = (exp_pc + 1) % 65536;
    @(negedge clock);
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3)      rand_word = {2'b00, 14'($urandom)};
    else if (r <= 6) rand_word = {2'b01, 14'($urandom)};
    else if (r <= 8) rand_word = {2'b10, 14'($urandom)};
    else             rand_word = {2'b11, 14'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    reset     = 1'b0;
    start     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    zero_flag = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_opcode", 32'(opcode), 32'd3);
    check("rst_pc_in", 32'(pc_in), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("rst_pc_opcode", 32'(opcode), 32'd0);
    check("rst_pc_busy", 32'(busy), 32'd1);
    check("rst_pc_req", 32'(mem_req), 32'd0);
    exp_pc = 0;
    @(negedge clock);

    // Directed: sequential NOPs, jump, branch, halt/resume, wait states
    do_fetch(16'h0000, 0, 1'b0);
    do_fetch(16'h0000, 0, 1'b0);
    do_fetch(16'h4123, 0, 1'b0);
    do_fetch(16'h4010, 1, 1'b0);
    do_fetch(16'hBFFE, 0, 1'b1);
    do_fetch(16'h4010, 0, 1'b0);
    do_fetch(16'hBFFE, 2, 1'b0);
    do_fetch(16'h4005, 0, 1'b0);
    do_fetch(16'hC000, 0, 1'b0);
    resume(20);
    do_fetch(16'h0000, 3, 1'b0);

    // Wrap: preload the PC to 0xFFFE while halted, resume to 0xFFFF
    do_fetch(16'hC000, 0, 1'b0);
    pc_load     = 1'b1;
    pc_load_val = 16'hFFFE;
    @(negedge clock);
    pc_load = 1'b0;
    exp_pc  = 16'hFFFE;
    resume(1);
    do_fetch(16'h0000, 0, 1'b0);
    do_fetch(16'h0000, 1, 1'b1);

    // Random programs
    for (int k = 0; k < 250; k++) begin
      w = rand_word();
      do_fetch(w, $urandom_range(0, 3), 1'($urandom));
      if (w[15:14] == 2'b11) resume($urandom_range(0, 3));
    end

    // Reset during a memory wait, then a late ack
    for (int i = 0; i < 2; i++) begin
      check("wait_req", 32'(mem_req), 32'd1);
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_opcode", 32'(opcode), 32'd3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_instr", 32'(instr), 32'd0);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("late_ack_req", 32'(mem_req), 32'd0);
      check("late_ack_instr", 32'(instr), 32'd0);
      check("late_ack_valid", 32'(instr_valid), 32'd0);
      check("late_ack_opcode", 32'(opcode), 32'd3);
    end
    mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
